// File: rtl/nonce_search_ctrl.sv
// Nonce search controller: walks an inclusive nonce range one candidate per cycle,
// checks the external combinational hash against a difficulty target, reports the first hit.
module nonce_search_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [95:0] bloque_bytes,
  input  logic [31:0] nonce_start,
  input  logic [31:0] nonce_limit,
  input  logic [7:0]  target,
  input  logic [23:0] hash_in,
  output logic [95:0] bloque_out,
  output logic [31:0] nonce_out,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] nonce_found,
  output logic [23:0] hash_found,
  output logic [31:0] attempts
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEARCH    = 2'd1,
    FOUND     = 2'd2,
    EXHAUSTED = 2'd3
  } state_t;

  state_t      state_q;
  logic [95:0] bloque_q;
  logic [31:0] nonce_q;
  logic [31:0] limit_q;
  logic [7:0]  target_q;
  logic        busy_q;
  logic        done_q;
  logic        found_q;
  logic [31:0] nonce_found_q;
  logic [23:0] hash_found_q;
  logic [31:0] attempts_q;

  logic        hash_valid_d;
  logic        at_limit_d;
  logic [31:0] attempts_d;

  assign hash_valid_d = (hash_in[23:16] == 8'h00) && (hash_in[15:8] < target_q);
  assign at_limit_d   = (nonce_q == limit_q);
  assign attempts_d   = attempts_q + 32'd1;

  // Search FSM; every output is a register written here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      bloque_q      <= 96'd0;
      nonce_q       <= 32'd0;
      limit_q       <= 32'd0;
      target_q      <= 8'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      nonce_found_q <= 32'd0;
      hash_found_q  <= 24'd0;
      attempts_q    <= 32'd0;
    end else begin
      case (state_q)
        SEARCH: begin
          // Abort outranks a same-cycle hit or limit; counters and results are kept.
          if (stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
          end else if (hash_valid_d) begin
            state_q       <= FOUND;
            nonce_found_q <= nonce_q;
            hash_found_q  <= hash_in;
            attempts_q    <= attempts_d;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            found_q       <= 1'b1;
          end else if (at_limit_d) begin
            state_q    <= EXHAUSTED;
            attempts_q <= attempts_d;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            found_q    <= 1'b0;
          end else begin
            nonce_q    <= nonce_q + 32'd1;
            attempts_q <= attempts_d;
          end
        end
        IDLE, FOUND, EXHAUSTED: begin
          if (start) begin
            bloque_q      <= bloque_bytes;
            target_q      <= target;
            limit_q       <= nonce_limit;
            nonce_q       <= nonce_start;
            attempts_q    <= 32'd0;
            found_q       <= 1'b0;
            nonce_found_q <= 32'd0;
            hash_found_q  <= 24'd0;
            // An empty range finishes immediately without evaluating anything.
            if (nonce_start > nonce_limit) begin
              state_q <= EXHAUSTED;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= SEARCH;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= state_q;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          found_q <= 1'b0;
        end
      endcase
    end
  end

  assign bloque_out  = bloque_q;
  assign nonce_out   = nonce_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign nonce_found = nonce_found_q;
  assign hash_found  = hash_found_q;
  assign attempts    = attempts_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Scoreboard bench for nonce_search_ctrl: stimulus queues expected results, a monitor
// pops and compares on every done rising edge or explicit snapshot request.
module tb_nonce_search_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [95:0] bloque_bytes;
  logic [31:0] nonce_start;
  logic [31:0] nonce_limit;
  logic [7:0]  target;
  logic [23:0] hash_in;
  logic [95:0] bloque_out;
  logic [31:0] nonce_out;
  logic        busy;
  logic        done;
  logic        found;
  logic [31:0] nonce_found;
  logic [23:0] hash_found;
  logic [31:0] attempts;

  logic        hen;
  logic [31:0] hn;
  logic [23:0] hh;
  logic        snap;
  int          cyc;
  int          n_cmp;
  int          n_fail;

  localparam logic [95:0] B1 = 96'h0123456789ABCDEF_DEADBEEF;
  localparam logic [95:0] B2 = 96'hCAFEF00D_55AA55AA_13579BDF;

  typedef struct {
    string       tag;
    logic        busy;
    logic        done;
    logic        found;
    logic [31:0] nonce_out;
    logic [95:0] bloque_out;
    logic [31:0] nonce_found;
    logic [23:0] hash_found;
    logic [31:0] attempts;
    int          exp_cyc;
  } exp_t;

  exp_t sb_q[$];

  nonce_search_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .bloque_bytes(bloque_bytes),
    .nonce_start (nonce_start),
    .nonce_limit (nonce_limit),
    .target      (target),
    .hash_in     (hash_in),
    .bloque_out  (bloque_out),
    .nonce_out   (nonce_out),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .nonce_found (nonce_found),
    .hash_found  (hash_found),
    .attempts    (attempts)
  );

  // Hash stub: one programmable matching nonce, everything else hashes to all ones.
  assign hash_in = (hen && nonce_out == hn) ? hh : 24'hFFFFFF;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(string tag, logic b, logic d, logic f, logic [31:0] no,
                              logic [95:0] bo, logic [31:0] nf, logic [23:0] hf,
                              logic [31:0] att);
    exp_t e;
    e.tag = tag; e.busy = b; e.done = d; e.found = f; e.nonce_out = no;
    e.bloque_out = bo; e.nonce_found = nf; e.hash_found = hf; e.attempts = att;
    e.exp_cyc = -1;
    return e;
  endfunction

  task automatic chk(string tag, string fld, logic [95:0] act, logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got=%0h want=%0h", tag, fld, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs with the queue head when done rises or a snapshot is requested.
  initial begin
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if ((done === 1'b1 && prev_done !== 1'b1) || snap) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_event got=done:%0b want=no_event", done);
        end else begin
          e = sb_q.pop_front();
          chk(e.tag, "busy",        96'(busy),        96'(e.busy));
          chk(e.tag, "done",        96'(done),        96'(e.done));
          chk(e.tag, "found",       96'(found),       96'(e.found));
          chk(e.tag, "nonce_out",   96'(nonce_out),   96'(e.nonce_out));
          chk(e.tag, "bloque_out",  bloque_out,       e.bloque_out);
          chk(e.tag, "nonce_found", 96'(nonce_found), 96'(e.nonce_found));
          chk(e.tag, "hash_found",  96'(hash_found),  96'(e.hash_found));
          chk(e.tag, "attempts",    96'(attempts),    96'(e.attempts));
          if (e.exp_cyc >= 0) chk(e.tag, "done_edge", 96'(cyc), 96'(e.exp_cyc));
        end
      end
      prev_done = done;
    end
  end

  task automatic go(logic [95:0] b, logic [31:0] ns, logic [31:0] nl, logic [7:0] tg,
                    exp_t e, int lat, bit push);
    @(negedge clk);
    bloque_bytes = b; nonce_start = ns; nonce_limit = nl; target = tg;
    start = 1'b1;
    e.exp_cyc = cyc + 1 + lat;
    if (push) sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(string tag);
    for (int k = 0; k < 300; k++) begin
      if (done === 1'b1) return;
      @(negedge clk);
    end
    n_cmp++;
    n_fail++;
    $display("FAIL %s.timeout got=done:%0b want=done:1", tag, done);
  endtask

  task automatic wait_nonce(string tag, logic [31:0] v);
    for (int k = 0; k < 300; k++) begin
      if (busy === 1'b1 && nonce_out === v) return;
      @(negedge clk);
    end
    n_cmp++;
    n_fail++;
    $display("FAIL %s.timeout got=nonce:%0h want=nonce:%0h", tag, nonce_out, v);
  endtask

  task automatic snapshot(exp_t e);
    sb_q.push_back(e);
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=running want=finished");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc = 0; n_cmp = 0; n_fail = 0; snap = 1'b0;
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    bloque_bytes = 96'd0; nonce_start = 32'd0; nonce_limit = 32'd0; target = 8'd0;
    hen = 1'b0; hn = 32'd0; hh = 24'hFFFFFF;
    repeat (2) @(negedge clk);
    snapshot(mk("reset", 1'b0, 1'b0, 1'b0, 32'd0, 96'd0, 32'd0, 24'd0, 32'd0));
    reset = 1'b1;

    // Match at nonce 5 in 0..100, then hold in FOUND.
    hen = 1'b1; hn = 32'd5; hh = 24'h000A00;
    go(B1, 32'd0, 32'd100, 8'h10,
       mk("match5", 1'b0, 1'b1, 1'b1, 32'd5, B1, 32'd5, 24'h000A00, 32'd6), 6, 1'b1);
    wait_done("match5");
    repeat (3) @(negedge clk);
    snapshot(mk("hold_found", 1'b0, 1'b1, 1'b1, 32'd5, B1, 32'd5, 24'h000A00, 32'd6));

    // No match anywhere: range 10..13 exhausts.
    hen = 1'b0;
    go(B2, 32'd10, 32'd13, 8'h10,
       mk("exh10_13", 1'b0, 1'b1, 1'b0, 32'd13, B2, 32'd0, 24'd0, 32'd4), 4, 1'b1);
    wait_done("exh10_13");

    // Strict less-than on the target byte.
    hen = 1'b1; hn = 32'd3; hh = 24'h001000;
    go(B1, 32'd0, 32'd5, 8'h10,
       mk("tgt_eq", 1'b0, 1'b1, 1'b0, 32'd5, B1, 32'd0, 24'd0, 32'd6), 6, 1'b1);
    wait_done("tgt_eq");
    go(B1, 32'd0, 32'd5, 8'h11,
       mk("tgt_gt", 1'b0, 1'b1, 1'b1, 32'd3, B1, 32'd3, 24'h001000, 32'd4), 4, 1'b1);
    wait_done("tgt_gt");

    // Stop on the matching cycle wins; stop in IDLE is ignored; restart finds it.
    hn = 32'd5; hh = 24'h000A00;
    go(B2, 32'd0, 32'd100, 8'h10, mk("", 1'b0, 1'b0, 1'b0, 32'd0, 96'd0, 32'd0, 24'd0, 32'd0), 0, 1'b0);
    wait_nonce("stop", 32'd5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    snapshot(mk("stop", 1'b0, 1'b0, 1'b0, 32'd5, B2, 32'd0, 24'd0, 32'd5));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    snapshot(mk("stop_idle", 1'b0, 1'b0, 1'b0, 32'd5, B2, 32'd0, 24'd0, 32'd5));
    go(B2, 32'd0, 32'd100, 8'h10,
       mk("restart", 1'b0, 1'b1, 1'b1, 32'd5, B2, 32'd5, 24'h000A00, 32'd6), 6, 1'b1);
    wait_done("restart");

    // Start ignored mid-search, then reset at nonce 7 with start held high.
    hen = 1'b0;
    go(B1, 32'd0, 32'd100, 8'h10, mk("", 1'b0, 1'b0, 1'b0, 32'd0, 96'd0, 32'd0, 24'd0, 32'd0), 0, 1'b0);
    wait_nonce("rst_pre", 32'd2);
    start = 1'b1; nonce_start = 32'd50;
    @(negedge clk);
    start = 1'b0;
    wait_nonce("rst_mid", 32'd7);
    reset = 1'b0; start = 1'b1;
    @(negedge clk);
    snapshot(mk("rst_mid", 1'b0, 1'b0, 1'b0, 32'd0, 96'd0, 32'd0, 24'd0, 32'd0));
    snapshot(mk("rst_hold", 1'b0, 1'b0, 1'b0, 32'd0, 96'd0, 32'd0, 24'd0, 32'd0));
    reset = 1'b1; start = 1'b0;

    // Empty range, then the top of the nonce space without wrap.
    go(B2, 32'd50, 32'd40, 8'h10,
       mk("empty", 1'b0, 1'b1, 1'b0, 32'd50, B2, 32'd0, 24'd0, 32'd0), 0, 1'b1);
    wait_done("empty");
    go(B1, 32'hFFFFFFFE, 32'hFFFFFFFF, 8'h10,
       mk("top", 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, B1, 32'd0, 24'd0, 32'd2), 2, 1'b1);
    wait_done("top");
    repeat (3) @(negedge clk);
    snapshot(mk("no_wrap", 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, B1, 32'd0, 24'd0, 32'd2));

    repeat (3) @(negedge clk);
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL %s.missing got=no_event want=event", e.tag);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nonce_search_ctrl.md
NONCE_SEARCH_CTRL -- requirements
Module: nonce_search_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset; reset==0 at a rising edge of clk resets the block.
REQ-003 The block SHALL have port start, input, 1 bit: begin a search; sampled in IDLE, FOUND and EXHAUSTED only.
REQ-004 The block SHALL have port stop, input, 1 bit: abort the current search; sampled in SEARCH only.
REQ-005 The block SHALL have port bloque_bytes, input, 96 bits: block header to hash; captured at start.
REQ-006 The block SHALL have ports nonce_start and nonce_limit, input, 32 bits each: inclusive search range; captured at start.
REQ-007 The block SHALL have port target, input, 8 bits: difficulty threshold; captured at start.
REQ-008 The block SHALL have port hash_in, input, 24 bits: combinational hash of bloque_out and nonce_out, returned in the same cycle.
REQ-009 The block SHALL have port bloque_out, output, 96 bits: registered copy of the captured bloque_bytes, driven to the hash unit.
REQ-010 The block SHALL have port nonce_out, output, 32 bits: registered candidate nonce, driven to the hash unit.
REQ-011 The block SHALL have output ports busy, done and found, 1 bit each: status flags.
REQ-012 The block SHALL have output ports nonce_found (32 bits), hash_found (24 bits) and attempts (32 bits): the search result.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SEARCH, FOUND, EXHAUSTED.
REQ-014 The valid-hash predicate SHALL be: hash_in[23:16]==8'h00 AND hash_in[15:8] < captured target, compared unsigned.
REQ-015 On start==1 in IDLE, FOUND or EXHAUSTED, the next edge SHALL perform all of:
- capture bloque_bytes, target and nonce_limit;
- load nonce_out with nonce_start;
- clear attempts, found, done, nonce_found and hash_found;
- enter SEARCH.
REQ-016 Exception to REQ-015: if nonce_start > nonce_limit at start, the block SHALL go directly to EXHAUSTED, with attempts=0, done=1 and found=0.
REQ-017 In SEARCH the block SHALL evaluate exactly one nonce per cycle, namely the current nonce_out against the current hash_in.
REQ-018 In SEARCH, when the predicate is true (and stop==0), the next edge SHALL:
- latch nonce_found=nonce_out and hash_found=hash_in;
- increment attempts;
- set found=1 and done=1;
- enter FOUND.
REQ-019 In SEARCH, when the predicate is false and nonce_out==nonce_limit (and stop==0), the next edge SHALL increment attempts, set done=1 with found=0, and enter EXHAUSTED.
REQ-020 In SEARCH, in all other cases without stop, the next edge SHALL increment nonce_out and attempts by 1.
REQ-021 nonce_out SHALL never wrap: nonce_limit=32'hFFFFFFFF terminates after that nonce is evaluated.
REQ-022 stop==1 in SEARCH SHALL return the block to IDLE on the next edge with done=0 and found=0, and SHALL have priority over a simultaneous match or limit hit.
REQ-023 attempts SHALL be held after stop; nonce_found and hash_found SHALL be held after stop.
REQ-024 start and stop SHALL be ignored in SEARCH and IDLE respectively.
REQ-025 busy SHALL be 1 exactly in SEARCH.
REQ-026 done SHALL be 1 exactly in FOUND or EXHAUSTED; found SHALL be 1 exactly in FOUND.
REQ-027 Latency: a match at nonce N SHALL raise done at edge (N - nonce_start + 1) after the edge that sampled start, with attempts = N - nonce_start + 1.
REQ-028 Result outputs SHALL hold stable in FOUND and EXHAUSTED until the next accepted start.

Reset
REQ-029 reset==0 at any edge, including mid-SEARCH, SHALL force all of:
- state IDLE;
- busy=0, done=0, found=0;
- nonce_out=0, bloque_out=0, nonce_found=0, hash_found=0, attempts=0;
- captured target=0 and nonce_limit=0.
REQ-030 reset SHALL have priority over start and stop.
REQ-031 While reset is low, inputs SHALL be ignored.

Verification
REQ-032 Stub hash_in=24'h000A00 when nonce_out==5, else 24'hFFFFFF; target=8'h10, range 0..100, start pulse -> done=1 and found=1 six edges after start, nonce_found=5, hash_found=24'h000A00, attempts=6.
REQ-033 Stub always 24'hFFFFFF; range 10..13 -> EXHAUSTED after 4 edges, found=0, attempts=4, nonce_out=13.
REQ-034 Stub 24'h001000 at nonce 3 with target=8'h10 -> no match, since the comparison is strictly less than; target=8'h11 -> match at nonce 3.
REQ-035 stop asserted in the same cycle that nonce_out hits the matching nonce -> IDLE, done=0, found=0; restart with stop=0 -> match found.
REQ-036 reset=0 during SEARCH at nonce 7 -> next edge all outputs zero, busy=0; a start while reset=0 is ignored.
REQ-037 nonce_start=50, nonce_limit=40 -> EXHAUSTED after 1 edge, attempts=0; range FFFFFFFE..FFFFFFFF with no match -> EXHAUSTED, attempts=2, no wrap.
